// File: rtl/sifh_hist_arbiter.sv
// sifh_hist_arbiter: round-robin arbiter that serialises per-channel histogram
// bin increments into read-modify-write cycles on a dual-port RAM, plus a full
// clear sweep.
//
// Ports:
//   clk, res         clock, asynchronous active-low reset
//   req, req_addr    per-channel increment request and bin address
//   ack              one-hot pulse when a channel's increment is written
//   clr_start        clear request pulse; clr_busy/clr_done report the sweep
//   counts           RAM port-b read data (one cycle after read enable)
//   raddr, rEnable   port-b address and active-low read enable; meb port-b enable
//   waddr, wEnable   port-a address and write enable; mea port-a enable
//   newCounts        port-a write data
//   sat              pulse when an increment hits a saturated bin
module sifh_hist_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned AW    = 8,
    parameter int unsigned CW    = 8
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*AW-1:0]   req_addr,
    output logic [N_REQ-1:0]      ack,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  clr_done,
    input  logic [CW-1:0]         counts,
    output logic [AW-1:0]         raddr,
    output logic                  rEnable,
    output logic                  meb,
    output logic [AW-1:0]         waddr,
    output logic                  wEnable,
    output logic                  mea,
    output logic [CW-1:0]         newCounts,
    output logic                  sat
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [AW-1:0] ADDR_MAX = '1;
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RD    = 3'd2,
        S_CAP   = 3'd3,
        S_WR    = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     rr_q, rr_d;
    logic              pend_q, pend_d;
    logic [AW-1:0]     sweep_q, sweep_d;
    logic [PW-1:0]     win_q, win_d;
    logic [AW-1:0]     addr_q, addr_d;

    logic [N_REQ-1:0]  ack_q, ack_d;
    logic              clr_busy_q, clr_busy_d;
    logic              clr_done_q, clr_done_d;
    logic              sat_q, sat_d;
    logic              wen_q, wen_d;
    logic              mea_q, mea_d;
    logic              meb_q, meb_d;
    logic              ren_q, ren_d;
    logic [AW-1:0]     waddr_q, waddr_d;
    logic [AW-1:0]     raddr_q, raddr_d;
    logic [CW-1:0]     newcnt_q, newcnt_d;

    logic              win_found_c;
    logic [PW-1:0]     win_c;
    logic [PW-1:0]     cand_c;

    // Round-robin search starting at rr_q.
    always_comb begin
        win_found_c = 1'b0;
        win_c       = '0;
        cand_c      = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            cand_c = PW'((int'(rr_q) + k) % int'(N_REQ));
            if (!win_found_c && req[cand_c]) begin
                win_found_c = 1'b1;
                win_c       = cand_c;
            end
        end
    end

    // Next state, then registered outputs decoded from the next state so they
    // line up with the state they belong to.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        pend_d     = pend_q;
        sweep_d    = sweep_q;
        win_d      = win_q;
        addr_d     = addr_q;
        ack_d      = '0;
        clr_busy_d = 1'b0;
        clr_done_d = 1'b0;
        sat_d      = 1'b0;
        wen_d      = 1'b0;
        mea_d      = 1'b0;
        meb_d      = 1'b0;
        ren_d      = 1'b1;
        waddr_d    = waddr_q;
        raddr_d    = raddr_q;
        newcnt_d   = newcnt_q;

        case (state_q)
            S_IDLE: begin
                if (clr_start || pend_q) begin
                    state_d = S_CLEAR;
                    pend_d  = 1'b0;
                    sweep_d = '0;
                end else if (win_found_c) begin
                    state_d = S_RD;
                    win_d   = win_c;
                    addr_d  = req_addr[int'(win_c)*AW +: AW];
                end
            end
            S_RD: begin
                state_d = S_CAP;
                if (clr_start) pend_d = 1'b1;
            end
            S_CAP: begin
                state_d = S_WR;
                if (clr_start) pend_d = 1'b1;
            end
            S_WR: begin
                rr_d = (32'(win_q) == N_REQ - 1) ? '0 : win_q + 1'b1;
                // A clear latched during the RMW starts right after the ack.
                if (clr_start || pend_q) begin
                    state_d = S_CLEAR;
                    pend_d  = 1'b0;
                    sweep_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (sweep_q == ADDR_MAX) state_d = S_IDLE;
                else                     sweep_d = sweep_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_RD: begin
                raddr_d = addr_d;
                ren_d   = 1'b0;
                meb_d   = 1'b1;
            end
            S_WR: begin
                // counts is valid during CAP; the write-data register holds it +1.
                waddr_d       = addr_q;
                wen_d         = 1'b1;
                mea_d         = 1'b1;
                sat_d         = (counts == CNT_MAX);
                newcnt_d      = (counts == CNT_MAX) ? CNT_MAX : counts + 1'b1;
                ack_d[win_q]  = 1'b1;
            end
            S_CLEAR: begin
                waddr_d    = sweep_d;
                wen_d      = 1'b1;
                mea_d      = 1'b1;
                newcnt_d   = '0;
                clr_busy_d = 1'b1;
                clr_done_d = (sweep_d == ADDR_MAX);
            end
            default: ;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q    <= S_IDLE;
            rr_q       <= '0;
            pend_q     <= 1'b0;
            sweep_q    <= '0;
            win_q      <= '0;
            addr_q     <= '0;
            ack_q      <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
            sat_q      <= 1'b0;
            wen_q      <= 1'b0;
            mea_q      <= 1'b0;
            meb_q      <= 1'b0;
            ren_q      <= 1'b1;
            waddr_q    <= '0;
            raddr_q    <= '0;
            newcnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            pend_q     <= pend_d;
            sweep_q    <= sweep_d;
            win_q      <= win_d;
            addr_q     <= addr_d;
            ack_q      <= ack_d;
            clr_busy_q <= clr_busy_d;
            clr_done_q <= clr_done_d;
            sat_q      <= sat_d;
            wen_q      <= wen_d;
            mea_q      <= mea_d;
            meb_q      <= meb_d;
            ren_q      <= ren_d;
            waddr_q    <= waddr_d;
            raddr_q    <= raddr_d;
            newcnt_q   <= newcnt_d;
        end
    end

    assign ack       = ack_q;
    assign clr_busy  = clr_busy_q;
    assign clr_done  = clr_done_q;
    assign sat       = sat_q;
    assign wEnable   = wen_q;
    assign mea       = mea_q;
    assign meb       = meb_q;
    assign rEnable   = ren_q;
    assign waddr     = waddr_q;
    assign raddr     = raddr_q;
    assign newCounts = newcnt_q;

endmodule

// File: tb/tb_sifh_hist_arbiter.sv
// Testbench for sifh_hist_arbiter: a behavioural dual-port RAM plus a write
// scoreboard; each scenario pushes the writes it expects before driving stimulus.
module tb_sifh_hist_arbiter;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned AW    = 8;
    localparam int unsigned CW    = 8;
    localparam int unsigned DEPTH = 256;

    logic                 clk = 1'b0;
    logic                 res = 1'b1;
    logic [N_REQ-1:0]     req = '0;
    logic [N_REQ*AW-1:0]  req_addr = '0;
    logic                 clr_start = 1'b0;
    logic [CW-1:0]        counts = '0;
    logic [N_REQ-1:0]     ack;
    logic                 clr_busy, clr_done, rEnable, meb, wEnable, mea, sat;
    logic [AW-1:0]        raddr, waddr;
    logic [CW-1:0]        newCounts;

    sifh_hist_arbiter #(.N_REQ(N_REQ), .AW(AW), .CW(CW)) dut (
        .clk(clk), .res(res), .req(req), .req_addr(req_addr), .ack(ack),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .counts(counts), .raddr(raddr), .rEnable(rEnable), .meb(meb),
        .waddr(waddr), .wEnable(wEnable), .mea(mea), .newCounts(newCounts),
        .sat(sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]    addr;
        logic [CW-1:0]    data;
        logic [N_REQ-1:0] ack;
        logic             sat;
        logic             done;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [CW-1:0] mem    [DEPTH];
    logic [CW-1:0] shadow [DEPTH];
    int cmp_cnt = 0, err_cnt = 0;
    int cyc = 0;
    int sat_pulses = 0, done_pulses = 0, busy_cycles = 0;

    // RAM model: port-b read data one cycle after enable, port-a synchronous write.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rEnable && meb) counts <= mem[raddr];
        if (wEnable && mea)  mem[waddr] <= newCounts;
    end

    // Scoreboard: every RAM write must match the next expected entry.
    always @(negedge clk) begin
        if (sat)      sat_pulses++;
        if (clr_done) done_pulses++;
        if (clr_busy) busy_cycles++;
        cmp_cnt++;
        if (wEnable && mea) begin
            if (sb.size() == 0) begin
                err_cnt++;
                $display("FAIL sb_unexpected_write: addr=%0h data=%0h ack=%b", waddr, newCounts, ack);
            end else begin
                mon_e = sb.pop_front();
                if ({waddr, newCounts, ack, sat, clr_done} !==
                    {mon_e.addr, mon_e.data, mon_e.ack, mon_e.sat, mon_e.done}) begin
                    err_cnt++;
                    $display("FAIL sb_write: got addr=%0h data=%0h ack=%b sat=%b done=%b, expected addr=%0h data=%0h ack=%b sat=%b done=%b",
                             waddr, newCounts, ack, sat, clr_done,
                             mon_e.addr, mon_e.data, mon_e.ack, mon_e.sat, mon_e.done);
                end
            end
        end else if (ack !== '0) begin
            err_cnt++;
            $display("FAIL ack_without_write: ack=%b", ack);
        end
    end

    task automatic set_bin(input int a, input logic [CW-1:0] v);
        mem[a]    = v;
        shadow[a] = v;
    endtask

    task automatic set_addr(input int ch, input logic [AW-1:0] a);
        req_addr[ch*AW +: AW] = a;
    endtask

    // Expected saturating increment of bin a by channel ch.
    task automatic push_inc(input int a, input int ch);
        exp_t e;
        e.addr = AW'(a);
        e.sat  = (shadow[a] == 8'hFF);
        e.data = e.sat ? 8'hFF : shadow[a] + 8'd1;
        e.ack  = N_REQ'(1) << ch;
        e.done = 1'b0;
        shadow[a] = e.data;
        sb.push_back(e);
    endtask

    task automatic push_clear();
        exp_t e;
        for (int i = 0; i < int'(DEPTH); i++) begin
            e.addr = AW'(i);
            e.data = '0;
            e.ack  = '0;
            e.sat  = 1'b0;
            e.done = (i == int'(DEPTH) - 1);
            shadow[i] = '0;
            sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        logic [34:0] got;
        #1 res = 1'b0;
        #1;
        got = {ack, clr_busy, clr_done, sat, wEnable, mea, meb, rEnable, waddr, raddr, newCounts};
        cmp_cnt++;
        if (got !== {4'b0000, 7'b0000001, 24'h0}) begin
            err_cnt++;
            $display("FAIL reset_outputs: got %h expected %h", got, {4'b0000, 7'b0000001, 24'h0});
        end
        repeat (3) @(negedge clk);
        res = 1'b1;
        repeat (2) @(negedge clk);
        got = {ack, clr_busy, clr_done, sat, wEnable, mea, meb, rEnable, waddr, raddr, newCounts};
        cmp_cnt++;
        if (got !== {4'b0000, 7'b0000001, 24'h0}) begin
            err_cnt++;
            $display("FAIL idle_outputs: got %h expected %h", got, {4'b0000, 7'b0000001, 24'h0});
        end
    endtask

    task automatic test_fairness();
        logic [N_REQ-1:0] got [5];
        int when [5];
        int n = 0;
        for (int i = 0; i < 4; i++) begin
            set_addr(i, AW'(8'h20 + i));
            set_bin(8'h20 + i, CW'(10 * i + 1));
        end
        push_inc(8'h20, 0); push_inc(8'h21, 1); push_inc(8'h22, 2);
        push_inc(8'h23, 3); push_inc(8'h20, 0);
        @(negedge clk);
        req = 4'b1111;
        for (int t = 0; t < 60 && n < 5; t++) begin
            @(negedge clk);
            if (ack !== '0) begin
                got[n]  = ack;
                when[n] = cyc;
                n++;
                if (n == 5) req = '0;
            end
        end
        req = '0;
        cmp_cnt++;
        if (n != 5) begin
            err_cnt++;
            $display("FAIL fair_ack_count: got %0d expected 5", n);
        end
        for (int k = 0; k < n; k++) begin
            cmp_cnt++;
            if (got[k] !== (N_REQ'(1) << (k % 4))) begin
                err_cnt++;
                $display("FAIL fair_order[%0d]: got %b expected %b", k, got[k], N_REQ'(1) << (k % 4));
            end
            if (k > 0) begin
                cmp_cnt++;
                if (when[k] - when[k-1] != 4) begin
                    err_cnt++;
                    $display("FAIL fair_spacing[%0d]: got %0d expected 4", k, when[k] - when[k-1]);
                end
            end
        end
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        cmp_cnt++;
        if (sb.size() != 0) begin
            err_cnt++;
            $display("FAIL fair_drain: %0d writes outstanding, expected 0", sb.size());
        end
    endtask

    task automatic test_single();
        set_addr(0, 8'h05);
        set_bin(8'h05, 8'd3);
        push_inc(8'h05, 0);
        @(negedge clk);
        req = 4'b0001;
        @(negedge clk);
        cmp_cnt++;
        if ({raddr, rEnable, meb} !== {8'h05, 1'b0, 1'b1}) begin
            err_cnt++;
            $display("FAIL single_read: got raddr=%0h rEnable=%b meb=%b expected 05/0/1", raddr, rEnable, meb);
        end
        @(negedge clk);
        cmp_cnt++;
        if ({rEnable, meb, wEnable} !== 3'b100) begin
            err_cnt++;
            $display("FAIL single_cap: got rEnable/meb/wEnable=%b expected 100", {rEnable, meb, wEnable});
        end
        @(negedge clk);
        cmp_cnt++;
        if ({ack, waddr, newCounts, wEnable, mea} !== {4'b0001, 8'h05, 8'h04, 2'b11}) begin
            err_cnt++;
            $display("FAIL single_write: got ack=%b waddr=%0h data=%0h we=%b mea=%b expected 0001/05/04/1/1",
                     ack, waddr, newCounts, wEnable, mea);
        end
        req = '0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        cmp_cnt++;
        if (sb.size() != 0) begin
            err_cnt++;
            $display("FAIL single_drain: %0d writes outstanding, expected 0", sb.size());
        end
    endtask

    task automatic test_saturation();
        int s0 = sat_pulses;
        bit seen = 1'b0;
        set_addr(3, 8'h10);
        set_bin(8'h10, 8'hFF);
        push_inc(8'h10, 3);
        @(negedge clk);
        req = 4'b1000;
        for (int t = 0; t < 12 && !seen; t++) begin
            @(negedge clk);
            if (ack !== '0) begin seen = 1'b1; req = '0; end
        end
        req = '0;
        repeat (4) @(negedge clk);
        cmp_cnt++;
        if (!seen || sb.size() != 0) begin
            err_cnt++;
            $display("FAIL sat_ack: seen=%0d outstanding=%0d expected 1/0", seen, sb.size());
        end
        cmp_cnt++;
        if (sat_pulses - s0 != 1) begin
            err_cnt++;
            $display("FAIL sat_pulses: got %0d expected 1", sat_pulses - s0);
        end
        cmp_cnt++;
        if (mem[8'h10] !== 8'hFF) begin
            err_cnt++;
            $display("FAIL sat_ram: got %0h expected ff", mem[8'h10]);
        end
    endtask

    task automatic test_clear();
        int b0 = busy_cycles;
        int d0 = done_pulses;
        bit seen = 1'b0;
        set_addr(1, 8'h30);
        push_clear();
        push_inc(8'h30, 1);
        @(negedge clk);
        clr_start = 1'b1;
        req = 4'b0010;
        @(negedge clk);
        clr_start = 1'b0;
        repeat (100) @(negedge clk);
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        for (int t = 0; t < 400 && !seen; t++) begin
            @(negedge clk);
            if (ack !== '0) begin seen = 1'b1; req = '0; end
        end
        req = '0;
        repeat (4) @(negedge clk);
        cmp_cnt++;
        if (!seen || sb.size() != 0) begin
            err_cnt++;
            $display("FAIL clear_flow: ack_seen=%0d outstanding=%0d expected 1/0", seen, sb.size());
        end
        cmp_cnt++;
        if (busy_cycles - b0 != 256) begin
            err_cnt++;
            $display("FAIL clear_busy_cycles: got %0d expected 256", busy_cycles - b0);
        end
        cmp_cnt++;
        if (done_pulses - d0 != 1) begin
            err_cnt++;
            $display("FAIL clear_done_pulses: got %0d expected 1", done_pulses - d0);
        end
    endtask

    task automatic test_collision();
        set_addr(2, 8'h50);
        set_bin(8'h50, 8'h07);
        push_inc(8'h50, 2);
        push_clear();
        @(negedge clk);
        req = 4'b0100;
        @(negedge clk);
        cmp_cnt++;
        if ({rEnable, raddr} !== {1'b0, 8'h50}) begin
            err_cnt++;
            $display("FAIL coll_rd: got rEnable=%b raddr=%0h expected 0/50", rEnable, raddr);
        end
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        @(negedge clk);
        cmp_cnt++;
        if ({ack, clr_busy} !== {4'b0100, 1'b0}) begin
            err_cnt++;
            $display("FAIL coll_ack: got ack=%b busy=%b expected 0100/0", ack, clr_busy);
        end
        req = '0;
        @(negedge clk);
        cmp_cnt++;
        if ({wEnable, clr_busy, waddr, ack} !== {1'b1, 1'b1, 8'h00, 4'b0000}) begin
            err_cnt++;
            $display("FAIL coll_clear_start: got we=%b busy=%b waddr=%0h ack=%b expected 1/1/00/0000",
                     wEnable, clr_busy, waddr, ack);
        end
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        cmp_cnt++;
        if (sb.size() != 0) begin
            err_cnt++;
            $display("FAIL coll_drain: %0d writes outstanding, expected 0", sb.size());
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [34:0] got;
        int d0 = done_pulses;
        bit found = 1'b0;
        push_clear();
        @(negedge clk);
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        for (int t = 0; t < 300 && !found; t++) begin
            if (clr_busy && waddr == 8'h40) found = 1'b1;
            else @(negedge clk);
        end
        cmp_cnt++;
        if (!found) begin
            err_cnt++;
            $display("FAIL rst_mid_reach: sweep address 40 not reached, found=%0d expected 1", found);
        end
        #2 res = 1'b0;
        #1;
        got = {ack, clr_busy, clr_done, sat, wEnable, mea, meb, rEnable, waddr, raddr, newCounts};
        cmp_cnt++;
        if (got !== {4'b0000, 7'b0000001, 24'h0}) begin
            err_cnt++;
            $display("FAIL rst_mid_outputs: got %h expected %h", got, {4'b0000, 7'b0000001, 24'h0});
        end
        sb.delete();
        repeat (2) @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        cmp_cnt++;
        if (done_pulses != d0) begin
            err_cnt++;
            $display("FAIL rst_mid_no_done: got %0d done pulses expected 0", done_pulses - d0);
        end
        push_clear();
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        cmp_cnt++;
        if ({wEnable, waddr} !== {1'b1, 8'h00}) begin
            err_cnt++;
            $display("FAIL rst_mid_restart: got we=%b waddr=%0h expected 1/00", wEnable, waddr);
        end
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        cmp_cnt++;
        if (sb.size() != 0) begin
            err_cnt++;
            $display("FAIL rst_mid_drain: %0d writes outstanding, expected 0", sb.size());
        end
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i]    = '0;
            shadow[i] = '0;
        end
        test_reset();
        test_fairness();
        test_single();
        test_saturation();
        test_clear();
        test_collision();
        test_reset_mid_clear();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", cmp_cnt, err_cnt);
        $fatal(1);
    end

endmodule
